// File: rtl/centroid_divider.sv
// Per-label centroid update: floor(sum / count) via restoring division, x and y in parallel.
// Define CONVERGE_DETECT_EN to add the pass-level converged flag (tied 0 otherwise).
module centroid_divider #(
    parameter int unsigned NUM_LABEL = 8,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_LABEL*ACC_WIDTH-1:0] xaccu_bus,
    input  logic [NUM_LABEL*ACC_WIDTH-1:0] yaccu_bus,
    input  logic [NUM_LABEL*CNT_WIDTH-1:0] count_bus,
    input  logic                           cent_load,
    input  logic [2:0]                     cent_label,
    input  logic [WIDTH-1:0]               cent_x_in,
    input  logic [WIDTH-1:0]               cent_y_in,
    output logic [NUM_LABEL*WIDTH-1:0]     centx_bus,
    output logic [NUM_LABEL*WIDTH-1:0]     centy_bus,
    output logic                           busy,
    output logic                           done,
    output logic                           converged
);

    localparam int unsigned LBL_W = (NUM_LABEL > 1) ? $clog2(NUM_LABEL) : 1;
    localparam int unsigned BIT_W = (ACC_WIDTH > 1) ? $clog2(ACC_WIDTH) : 1;
    localparam int unsigned REM_W = CNT_WIDTH + 1;
    localparam logic [LBL_W-1:0] LAST_K   = LBL_W'(NUM_LABEL - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(ACC_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DIV   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [LBL_W-1:0]       k_q, k_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   hold_q, hold_d;
    logic [ACC_WIDTH-1:0]   xq_q, xq_d, yq_q, yq_d;
    logic [CNT_WIDTH-1:0]   xr_q, xr_d, yr_q, yr_d;
    logic [CNT_WIDTH-1:0]   div_q, div_d;
    logic [WIDTH-1:0]       cent_x_q [NUM_LABEL];
    logic [WIDTH-1:0]       cent_x_d [NUM_LABEL];
    logic [WIDTH-1:0]       cent_y_q [NUM_LABEL];
    logic [WIDTH-1:0]       cent_y_d [NUM_LABEL];
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [ACC_WIDTH-1:0]   x_sel, y_sel;
    logic [CNT_WIDTH-1:0]   cnt_sel;

    // One restoring step: returns {remainder, dividend shifted with new quotient bit}.
    // The remainder stays below the divisor, so CNT_WIDTH bits always hold it.
    function automatic logic [CNT_WIDTH+ACC_WIDTH-1:0] div_step(
        input logic [CNT_WIDTH-1:0] rem,
        input logic [ACC_WIDTH-1:0] q,
        input logic [CNT_WIDTH-1:0] d
    );
        logic [REM_W-1:0]     sh;
        logic [CNT_WIDTH-1:0] rem_n;
        logic                 qbit;
        sh = {rem, q[ACC_WIDTH-1]};
        if (sh >= {1'b0, d}) begin
            rem_n = CNT_WIDTH'(sh - {1'b0, d});
            qbit  = 1'b1;
        end else begin
            rem_n = sh[CNT_WIDTH-1:0];
            qbit  = 1'b0;
        end
        return {rem_n, q[ACC_WIDTH-2:0], qbit};
    endfunction

    // Operand mux for the current label
    always_comb begin
        x_sel   = '0;
        y_sel   = '0;
        cnt_sel = '0;
        for (int unsigned i = 0; i < NUM_LABEL; i++) begin
            if (k_q == LBL_W'(i)) begin
                x_sel   = xaccu_bus[i*ACC_WIDTH +: ACC_WIDTH];
                y_sel   = yaccu_bus[i*ACC_WIDTH +: ACC_WIDTH];
                cnt_sel = count_bus[i*CNT_WIDTH +: CNT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = (cnt_sel == '0) ? S_WRITE : S_DIV;
            S_DIV:   if (bit_cnt_q == LAST_BIT) state_d = S_WRITE;
            S_WRITE: state_d = (k_q == LAST_K) ? S_DONE : S_LOAD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Label walk, divider datapath and centroid storage
    always_comb begin
        k_d       = k_q;
        bit_cnt_d = bit_cnt_q;
        hold_d    = hold_q;
        xq_d      = xq_q;
        yq_d      = yq_q;
        xr_d      = xr_q;
        yr_d      = yr_q;
        div_d     = div_q;
        cent_x_d  = cent_x_q;
        cent_y_d  = cent_y_q;
        case (state_q)
            S_IDLE: begin
                if (start) k_d = '0;
                for (int unsigned i = 0; i < NUM_LABEL; i++) begin
                    if (cent_load && (32'(cent_label) == i)) begin
                        cent_x_d[i] = cent_x_in;
                        cent_y_d[i] = cent_y_in;
                    end
                end
            end
            S_LOAD: begin
                xq_d      = x_sel;
                yq_d      = y_sel;
                div_d     = cnt_sel;
                xr_d      = '0;
                yr_d      = '0;
                bit_cnt_d = '0;
                hold_d    = (cnt_sel == '0);
            end
            S_DIV: begin
                {xr_d, xq_d} = div_step(xr_q, xq_q, div_q);
                {yr_d, yq_d} = div_step(yr_q, yq_q, div_q);
                bit_cnt_d    = bit_cnt_q + 1'b1;
            end
            S_WRITE: begin
                if (!hold_q) begin
                    cent_x_d[k_q] = xq_q[WIDTH-1:0];
                    cent_y_d[k_q] = yq_q[WIDTH-1:0];
                end
                if (k_q != LAST_K) k_d = k_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q       <= '0;
            bit_cnt_q <= '0;
            hold_q    <= 1'b0;
            xq_q      <= '0;
            yq_q      <= '0;
            xr_q      <= '0;
            yr_q      <= '0;
            div_q     <= '0;
            cent_x_q  <= '{default: '0};
            cent_y_q  <= '{default: '0};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            k_q       <= k_d;
            bit_cnt_q <= bit_cnt_d;
            hold_q    <= hold_d;
            xq_q      <= xq_d;
            yq_q      <= yq_d;
            xr_q      <= xr_d;
            yr_q      <= yr_d;
            div_q     <= div_d;
            cent_x_q  <= cent_x_d;
            cent_y_q  <= cent_y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    for (genvar i = 0; i < NUM_LABEL; i++) begin : g_out
        assign centx_bus[i*WIDTH +: WIDTH] = cent_x_q[i];
        assign centy_bus[i*WIDTH +: WIDTH] = cent_y_q[i];
    end

    assign busy = busy_q;
    assign done = done_q;

`ifdef CONVERGE_DETECT_EN
    logic chg_q, chg_d;
    logic conv_q, conv_d;

    // Flag any centroid change during the pass; converged is published with done
    always_comb begin
        chg_d  = chg_q;
        conv_d = conv_q;
        if ((state_q == S_IDLE) && start) begin
            chg_d  = 1'b0;
            conv_d = 1'b0;
        end
        if ((state_q == S_WRITE) && !hold_q &&
            ((xq_q[WIDTH-1:0] != cent_x_q[k_q]) || (yq_q[WIDTH-1:0] != cent_y_q[k_q]))) begin
            chg_d = 1'b1;
        end
        if (state_d == S_DONE) conv_d = !chg_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_q  <= 1'b0;
            conv_q <= 1'b0;
        end else begin
            chg_q  <= chg_d;
            conv_q <= conv_d;
        end
    end

    assign converged = conv_q;
`else
    assign converged = 1'b0;
`endif

endmodule

// File: tb/tb_centroid_divider.sv
// Scoreboard bench for centroid_divider: directed passes, expectations queued at start,
// checked by an independent monitor when done pulses.
`timescale 1ns/1ps
module tb_centroid_divider;

    localparam int unsigned NL = 8;
    localparam int unsigned W  = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [NL*AW-1:0]  xaccu_bus = '0;
    logic [NL*AW-1:0]  yaccu_bus = '0;
    logic [NL*CW-1:0]  count_bus = '0;
    logic              cent_load = 1'b0;
    logic [2:0]        cent_label = '0;
    logic [W-1:0]      cent_x_in = '0;
    logic [W-1:0]      cent_y_in = '0;
    logic [NL*W-1:0]   centx_bus;
    logic [NL*W-1:0]   centy_bus;
    logic              busy;
    logic              done;
    logic              converged;

    centroid_divider #(
        .NUM_LABEL(NL), .WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .xaccu_bus(xaccu_bus), .yaccu_bus(yaccu_bus), .count_bus(count_bus),
        .cent_load(cent_load), .cent_label(cent_label),
        .cent_x_in(cent_x_in), .cent_y_in(cent_y_in),
        .centx_bus(centx_bus), .centy_bus(centy_bus),
        .busy(busy), .done(done), .converged(converged)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL*W-1:0] ex;
        logic [NL*W-1:0] ey;
        logic            conv;
        int              lat;
        int              t_acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;
    int   cyc = 0;
    int   exp_x[NL];
    int   exp_y[NL];
`ifdef CONVERGE_DETECT_EN
    localparam logic CONV_2ND = 1'b1;
`else
    localparam logic CONV_2ND = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Monitor: every done pulse consumes one expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                for (int i = 0; i < NL; i++) begin
                    check($sformatf("centx[%0d]", i), 32'(centx_bus[i*W +: W]), 32'(e.ex[i*W +: W]));
                    check($sformatf("centy[%0d]", i), 32'(centy_bus[i*W +: W]), 32'(e.ey[i*W +: W]));
                end
                check("latency", 32'(cyc - e.t_acc + 1), 32'(e.lat));
                check("converged", 32'(converged), 32'(e.conv));
            end
        end
    end

    task automatic set_label(input int k, input int x, input int y, input int c);
        xaccu_bus[k*AW +: AW] = 32'(x);
        yaccu_bus[k*AW +: AW] = 32'(y);
        count_bus[k*CW +: CW] = 10'(c);
    endtask

    task automatic set_exp(input int k, input int x, input int y);
        exp_x[k] = x;
        exp_y[k] = y;
    endtask

    task automatic vec_a();
        for (int i = 0; i < NL; i++) begin
            set_label(i, 400, 800, 4);
            set_exp(i, 100, 200);
        end
    endtask

    task automatic vec_c();
        set_label(0, 67042305, 10, 1023); set_exp(0, 65535, 0);
        set_label(1, 10, 11, 3);          set_exp(1, 3, 3);
        set_label(2, 100, 6, 7);          set_exp(2, 14, 0);
        set_label(3, 65535, 0, 1);        set_exp(3, 65535, 0);
        set_label(4, 999999, 1000, 1000); set_exp(4, 999, 1);
        set_label(5, 1, 3, 2);            set_exp(5, 0, 1);
        set_label(6, 12345, 54321, 5);    set_exp(6, 2469, 10864);
        set_label(7, 4096, 65535, 16);    set_exp(7, 256, 4095);
    endtask

    task automatic start_pass(input int lat, input logic conv, input bit ld,
                              input int lbl, input int lx, input int ly);
        exp_t e;
        @(negedge clk);
        start      = 1'b1;
        cent_load  = ld;
        cent_label = 3'(lbl);
        cent_x_in  = 16'(lx);
        cent_y_in  = 16'(ly);
        @(posedge clk);
        #1;
        start     = 1'b0;
        cent_load = 1'b0;
        for (int i = 0; i < NL; i++) begin
            e.ex[i*W +: W] = 16'(exp_x[i]);
            e.ey[i*W +: W] = 16'(exp_y[i]);
        end
        e.conv  = conv;
        e.lat   = lat;
        e.t_acc = cyc;
        sb.push_back(e);
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int n_before, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            if (n_done > n_before) seen = 1'b1;
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic run_pass(input int lat, input logic conv, input bit ld,
                            input int lbl, input int lx, input int ly);
        int nb;
        nb = n_done;
        start_pass(lat, conv, ld, lbl, lx, ly);
        wait_done(nb, 600);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_centx"}, 32'(centx_bus != '0), 32'd0);
        check({tag, "_centy"}, 32'(centy_bus != '0), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_conv"}, 32'(converged), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Uniform sums: exact division, full-length pass
        vec_a();
        run_pass(273, 1'b0, 1'b0, 0, 0, 0);

        // Zero-count label keeps a value loaded in the same cycle as start
        @(negedge clk);
        cent_load = 1'b1; cent_label = 3'd0; cent_x_in = 16'hFFFF; cent_y_in = 16'hFFFF;
        @(negedge clk);
        cent_load = 1'b0;
        for (int i = 0; i < NL; i++) begin
            set_label(i, 7, 7, 1);
            set_exp(i, 7, 7);
        end
        set_label(3, 999, 999, 0);
        set_exp(3, 16'h1234, 16'h0055);
        run_pass(241, 1'b0, 1'b1, 3, 16'h1234, 16'h0055);

        // Direct centroid load while idle
        @(negedge clk);
        cent_load = 1'b1; cent_label = 3'd6; cent_x_in = 16'h0BAD; cent_y_in = 16'h0C0D;
        @(negedge clk);
        cent_load = 1'b0;
        check("idle_load_x", 32'(centx_bus[6*W +: W]), 32'h0BAD);
        check("idle_load_y", 32'(centy_bus[6*W +: W]), 32'h0C0D);

        // Mixed values: truncation and full-range quotient
        vec_c();
        run_pass(273, 1'b0, 1'b0, 0, 0, 0);

        // Reset in the middle of label 2's division
        vec_a();
        start_pass(273, 1'b0, 1'b0, 0, 0, 0);
        repeat (80) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        run_pass(273, 1'b0, 1'b0, 0, 0, 0);

        // start and cent_load while busy are ignored
        vec_c();
        nb = n_done;
        start_pass(273, 1'b0, 1'b0, 0, 0, 0);
        repeat (50) @(posedge clk);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        cent_load = 1'b1; cent_label = 3'd1; cent_x_in = 16'hBEEF; cent_y_in = 16'hBEEF;
        @(negedge clk); cent_load = 1'b0;
        wait_done(nb, 600);
        repeat (10) @(negedge clk);
        check("no_extra_done", 32'(n_done - nb), 32'd1);

        // Two identical passes: second reports convergence when enabled
        vec_a();
        run_pass(273, 1'b0, 1'b0, 0, 0, 0);
        run_pass(273, CONV_2ND, 1'b0, 0, 0, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
